// File: rtl/mem_wb_pkg.sv
// mem_wb_pkg: shared widths and write-back source encodings for the MEM/WB stage.
package mem_wb_pkg;
  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int WBSEL_W    = 2;
  typedef enum logic [WBSEL_W-1:0] {
    WBSEL_ALU  = 2'd0,
    WBSEL_MEM  = 2'd1,
    WBSEL_LINK = 2'd2,
    WBSEL_RSV  = 2'd3
  } wbsel_t;
endpackage

// File: rtl/mem_wb_pipe_wb_select.sv
// wb_select: combinational 3:1 write-back mux; the reserved select falls back to the ALU result.
module wb_select
  import mem_wb_pkg::*;
#(
  parameter int DATA_W  = mem_wb_pkg::DATA_W,
  parameter int WBSEL_W = mem_wb_pkg::WBSEL_W
) (
  input  logic [WBSEL_W-1:0] i_sel,
  input  logic [DATA_W-1:0]  i_alu,
  input  logic [DATA_W-1:0]  i_mem,
  input  logic [DATA_W-1:0]  i_link,
  output logic [DATA_W-1:0]  o_data
);
  always_comb
    o_data = (i_sel == WBSEL_W'(WBSEL_MEM))  ? i_mem  :
             (i_sel == WBSEL_W'(WBSEL_LINK)) ? i_link : i_alu;
endmodule

// File: rtl/mem_wb_pipe.sv
// mem_wb_pipe: MEM/WB pipeline register with stall, flush, r0 write suppression and a one-deep bypass.
// Optional MEM_WB_PERF_EN adds stall and bubble event counters.
module mem_wb_pipe
  import mem_wb_pkg::*;
#(
  parameter int DATA_W     = mem_wb_pkg::DATA_W,
  parameter int REG_ADDR_W = mem_wb_pkg::REG_ADDR_W,
  parameter int WBSEL_W    = mem_wb_pkg::WBSEL_W
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  Stall,
  input  logic                  Flush,
  input  logic                  Valid_in,
  input  logic                  RegWrite,
  input  logic [WBSEL_W-1:0]    MemToReg,
  input  logic [DATA_W-1:0]     ALUResult,
  input  logic [DATA_W-1:0]     ReadData,
  input  logic [DATA_W-1:0]     LinkAddr,
  input  logic [REG_ADDR_W-1:0] R_destination,
  output logic                  Valid_out,
  output logic                  RegWrite_out,
  output logic [WBSEL_W-1:0]    MemToReg_out,
  output logic [DATA_W-1:0]     ALUResult_out,
  output logic [DATA_W-1:0]     ReadData_out,
  output logic [REG_ADDR_W-1:0] R_destination_out,
  output logic [DATA_W-1:0]     WriteData_out,
  output logic                  Byp_RegWrite,
  output logic [REG_ADDR_W-1:0] Byp_Rd,
  output logic [DATA_W-1:0]     Byp_Data
`ifdef MEM_WB_PERF_EN
  ,
  output logic [31:0]           Stall_cnt,
  output logic [31:0]           Bubble_cnt
`endif
);
  logic [DATA_W-1:0] w_wdata;
  logic              w_load;

  wb_select #(.DATA_W(DATA_W), .WBSEL_W(WBSEL_W)) u_wb_select (
    .i_sel  (MemToReg),
    .i_alu  (ALUResult),
    .i_mem  (ReadData),
    .i_link (LinkAddr),
    .o_data (w_wdata)
  );

  assign w_load = !Flush && !Stall;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Valid_out         <= 1'b0;
      RegWrite_out      <= 1'b0;
      MemToReg_out      <= '0;
      ALUResult_out     <= '0;
      ReadData_out      <= '0;
      R_destination_out <= '0;
      WriteData_out     <= '0;
    end else if (Flush) begin
      Valid_out         <= 1'b0;
      RegWrite_out      <= 1'b0;
      MemToReg_out      <= '0;
      ALUResult_out     <= '0;
      ReadData_out      <= '0;
      R_destination_out <= '0;
      WriteData_out     <= '0;
    end else if (!Stall) begin
      Valid_out         <= Valid_in;
      RegWrite_out      <= RegWrite && Valid_in && (R_destination != '0);
      MemToReg_out      <= MemToReg;
      ALUResult_out     <= ALUResult;
      ReadData_out      <= ReadData;
      R_destination_out <= R_destination;
      WriteData_out     <= w_wdata;
    end
  end

  // The bypass captures the write that is leaving WB, so it only advances on a real load edge.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Byp_RegWrite <= 1'b0;
      Byp_Rd       <= '0;
      Byp_Data     <= '0;
    end else if (w_load) begin
      Byp_RegWrite <= RegWrite_out;
      if (RegWrite_out) begin
        Byp_Rd   <= R_destination_out;
        Byp_Data <= WriteData_out;
      end
    end
  end

`ifdef MEM_WB_PERF_EN
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Stall_cnt  <= '0;
      Bubble_cnt <= '0;
    end else begin
      if (Stall && !Flush)
        Stall_cnt <= Stall_cnt + 32'd1;
      if (Flush || (w_load && !Valid_in))
        Bubble_cnt <= Bubble_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_mem_wb_pipe.sv
// tb_mem_wb_pipe: directed and randomized checks of mem_wb_pipe against a behavioural model.
module tb_mem_wb_pipe;
  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        Stall = 1'b0, Flush = 1'b0, Valid_in = 1'b0, RegWrite = 1'b0;
  logic [1:0]  MemToReg = '0;
  logic [31:0] ALUResult = '0, ReadData = '0, LinkAddr = '0;
  logic [4:0]  R_destination = '0;
  logic        Valid_out, RegWrite_out, Byp_RegWrite;
  logic [1:0]  MemToReg_out;
  logic [31:0] ALUResult_out, ReadData_out, WriteData_out, Byp_Data;
  logic [4:0]  R_destination_out, Byp_Rd;
`ifdef MEM_WB_PERF_EN
  logic [31:0] Stall_cnt, Bubble_cnt;
`endif

  mem_wb_pipe dut (
    .Clk(Clk), .Rst_n(Rst_n), .Stall(Stall), .Flush(Flush), .Valid_in(Valid_in),
    .RegWrite(RegWrite), .MemToReg(MemToReg), .ALUResult(ALUResult), .ReadData(ReadData),
    .LinkAddr(LinkAddr), .R_destination(R_destination), .Valid_out(Valid_out),
    .RegWrite_out(RegWrite_out), .MemToReg_out(MemToReg_out), .ALUResult_out(ALUResult_out),
    .ReadData_out(ReadData_out), .R_destination_out(R_destination_out),
    .WriteData_out(WriteData_out), .Byp_RegWrite(Byp_RegWrite), .Byp_Rd(Byp_Rd),
    .Byp_Data(Byp_Data)
`ifdef MEM_WB_PERF_EN
    , .Stall_cnt(Stall_cnt), .Bubble_cnt(Bubble_cnt)
`endif
  );

  always #5 Clk = ~Clk;

  int n_pass = 0, n_total = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: what WB must hold and what the last committed write was.
  logic        m_valid = 0, m_we = 0, m_bwe = 0;
  logic [1:0]  m_sel = 0;
  logic [31:0] m_alu = 0, m_mem = 0, m_wd = 0, m_bdata = 0, m_scnt = 0, m_bcnt = 0;
  logic [4:0]  m_rd = 0, m_brd = 0;

  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      {m_valid, m_we, m_bwe, m_sel, m_alu, m_mem, m_wd, m_bdata, m_rd, m_brd} = '0;
      m_scnt = 0;
      m_bcnt = 0;
    end else if (Flush) begin
      {m_valid, m_we, m_sel, m_alu, m_mem, m_wd, m_rd} = '0;
      m_bcnt++;
    end else if (Stall) begin
      m_scnt++;
    end else begin
      if (m_we) begin
        m_brd = m_rd;
        m_bdata = m_wd;
      end
      m_bwe = m_we;
      m_valid = Valid_in;
      m_we = RegWrite && Valid_in && R_destination != 0;
      m_sel = MemToReg;
      m_alu = ALUResult;
      m_mem = ReadData;
      m_rd = R_destination;
      m_wd = MemToReg == 1 ? ReadData : MemToReg == 2 ? LinkAddr : ALUResult;
      if (!Valid_in) m_bcnt++;
    end
  end

  always @(negedge Clk) if (check_en) begin
    chk("valid", Valid_out, m_valid);
    chk("regwrite", RegWrite_out, m_we);
    chk("memtoreg", MemToReg_out, m_sel);
    chk("alu", ALUResult_out, m_alu);
    chk("rdata", ReadData_out, m_mem);
    chk("rd", R_destination_out, m_rd);
    chk("wdata", WriteData_out, m_wd);
    chk("byp_we", Byp_RegWrite, m_bwe);
    chk("byp_rd", Byp_Rd, m_brd);
    chk("byp_data", Byp_Data, m_bdata);
`ifdef MEM_WB_PERF_EN
    chk("stall_cnt", Stall_cnt, m_scnt);
    chk("bubble_cnt", Bubble_cnt, m_bcnt);
`endif
  end

  // Apply inputs just after a falling edge; returns at the next falling edge.
  task automatic cyc(input bit st, input bit fl, input bit vi, input bit we, input logic [1:0] sel,
                     input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] lnk,
                     input logic [4:0] rd);
    Stall = st; Flush = fl; Valid_in = vi; RegWrite = we; MemToReg = sel;
    ALUResult = alu; ReadData = mem; LinkAddr = lnk; R_destination = rd;
    @(negedge Clk);
  endtask

  initial begin
    repeat (3) @(negedge Clk);
    check_en = 1'b1;
    chk("reset_wdata", WriteData_out, 32'h0);
    chk("reset_valid", Valid_out, 32'h0);
    cyc(0, 0, 1, 1, 0, 32'h77, 0, 0, 7);
    #2 Rst_n = 1'b0;
    #1 chk("async_reset_valid", Valid_out, 32'h0);
    @(negedge Clk);
    Rst_n = 1'b1;
    cyc(0, 0, 1, 1, 0, 32'h1234, 32'h9, 32'h9, 8);
    chk("t1_wdata", WriteData_out, 32'h1234);
    chk("t1_we", RegWrite_out, 32'h1);
    chk("t1_rd", R_destination_out, 32'h8);
    cyc(0, 0, 1, 1, 1, 32'h1, 32'hDEADBEEF, 32'h2, 9);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 1, 1, 2, $urandom, $urandom, $urandom, 5'($urandom));
      chk("t2_hold_wdata", WriteData_out, 32'hDEADBEEF);
      chk("t2_byp_rd", Byp_Rd, 32'h8);
      chk("t2_byp_data", Byp_Data, 32'h1234);
    end
    cyc(1, 1, 1, 1, 0, 32'h5, 32'h6, 32'h7, 4);
    chk("t3_valid", Valid_out, 32'h0);
    chk("t3_we", RegWrite_out, 32'h0);
    chk("t3_wdata", WriteData_out, 32'h0);
    chk("t3_byp_rd", Byp_Rd, 32'h8);
    chk("t3_byp_data", Byp_Data, 32'h1234);
    cyc(0, 0, 1, 1, 0, 32'h55, 0, 0, 0);
    chk("t4_we", RegWrite_out, 32'h0);
    chk("t4_valid", Valid_out, 32'h1);
    cyc(0, 0, 1, 1, 2, 32'h3, 32'h4, 32'h00400008, 31);
    chk("t4_byp_we", Byp_RegWrite, 32'h0);
    chk("t5_wdata", WriteData_out, 32'h00400008);
    cyc(0, 0, 1, 1, 3, 32'hA5A5, 32'h1111, 32'h2222, 3);
    chk("t5_byp_rd", Byp_Rd, 32'd31);
    chk("t5_byp_data", Byp_Data, 32'h00400008);
    chk("t5_sel3_wdata", WriteData_out, 32'hA5A5);
`ifdef MEM_WB_PERF_EN
    Rst_n = 1'b0;
    @(negedge Clk);
    Rst_n = 1'b1;
    repeat (4) cyc(1, 0, 1, 0, 0, 0, 0, 0, 1);
    repeat (2) cyc(0, 1, 1, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("t6_stall_cnt", Stall_cnt, 32'd4);
    chk("t6_bubble_cnt", Bubble_cnt, 32'd3);
    #2 Rst_n = 1'b0;
    #1 chk("t6_reset_cnt", Stall_cnt | Bubble_cnt, 32'h0);
    @(negedge Clk);
    Rst_n = 1'b1;
`endif
    for (int i = 0; i < 500; i++) begin
      logic [4:0] rd;
      rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      Stall = ($urandom_range(0, 3) == 0);
      Flush = ($urandom_range(0, 9) == 0);
      Valid_in = ($urandom_range(0, 4) != 0);
      RegWrite = $urandom_range(0, 1);
      MemToReg = 2'($urandom_range(0, 3));
      ALUResult = $urandom; ReadData = $urandom; LinkAddr = $urandom; R_destination = rd;
      if ($urandom_range(0, 49) == 0) begin
        #2 Rst_n = 1'b0;
        #1 Rst_n = 1'b1;
      end
      @(negedge Clk);
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
